// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel between the fetch stage and imem.
// Ports: imem_req_o/imem_addr_o (fetch -> mem), imem_ready_i (mem accepts),
//        imem_rvalid_i/imem_rdata_i (mem -> fetch, in order, one per accepted request).
interface fetch_stage_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  imem_req_o;
  logic [DATA_WIDTH-1:0] imem_addr_o;
  logic                  imem_ready_i;
  logic                  imem_rvalid_i;
  logic [DATA_WIDTH-1:0] imem_rdata_i;

  // Fetch-stage side.
  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ready_i,
    input  imem_rvalid_i,
    input  imem_rdata_i
  );

  // Instruction-memory side.
  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ready_i,
    output imem_rvalid_i,
    output imem_rdata_i
  );
endinterface

// File: rtl/fetch_stage.sv
// RV32I IF stage: owns the PC, issues one imem request at a time, drives IF/ID.
// Latency: acceptance -> IF/ID valid is response latency + 1 edge; 1 instr / 2 cycles at zero wait.
// Backpressure: imem_ready_i low holds the request; StallD_i parks a returned word in a holding buffer.
// Ports: clk, rst_n (sync, active low); PCSrcE_i/PCTargetE_i redirect; StallD_i/FlushD_i IF/ID control;
//        imem (fetch_stage_if.master) memory channel; instr_o/PC_F_o/PC_Plus4_F_o/validD_o IF/ID outputs.
module fetch_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(32'h0000_0000),
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(32'h0000_0013)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  PCSrcE_i,
  input  logic [DATA_WIDTH-1:0] PCTargetE_i,
  input  logic                  StallD_i,
  input  logic                  FlushD_i,
  fetch_stage_if.master         imem,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] PC_F_o,
  output logic [DATA_WIDTH-1:0] PC_Plus4_F_o,
  output logic                  validD_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DROP,
    S_HOLD
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] w_pc_nxt;
  logic [DATA_WIDTH-1:0] w_pc_plus4;
  logic [DATA_WIDTH-1:0] w_redirect_pc;

  // Holding buffer for a word that returned while decode was stalled.
  // Its occupancy is exactly "state is HOLD", so no separate valid bit is kept.
  logic [DATA_WIDTH-1:0] r_buf;
  logic                  w_capture;

  // Responses still owed for requests accepted before the most recent reset.
  // Those rvalids are swallowed so they are never mistaken for post-reset data.
  logic [1:0]            r_stale_cnt;
  logic [1:0]            w_pending;
  logic                  w_in_flight;

  logic                  w_accept;
  logic                  w_rvalid;
  logic                  w_deliver;
  logic [DATA_WIDTH-1:0] w_deliver_dat;

  logic [DATA_WIDTH-1:0] r_instr;
  logic [DATA_WIDTH-1:0] r_pc_f;
  logic [DATA_WIDTH-1:0] r_pc_plus4_f;
  logic                  r_valid_d;

  assign w_pc_plus4    = r_pc + DATA_WIDTH'(4);
  // Word-align the target; masking (rather than slicing) keeps every input bit in use.
  assign w_redirect_pc = PCTargetE_i & ~DATA_WIDTH'(3);

  assign w_accept    = (r_state == S_REQ) && imem.imem_ready_i;
  assign w_in_flight = (r_state == S_WAIT) || (r_state == S_DROP);
  assign w_rvalid    = imem.imem_rvalid_i && (r_stale_cnt == 2'd0);
  assign w_pending   = r_stale_cnt + 2'(w_in_flight) + 2'(w_accept);

  assign imem.imem_req_o  = (r_state == S_REQ);
  assign imem.imem_addr_o = r_pc;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state, next PC, deliver/capture strobes
  // A redirect always wins over a same-cycle delivery. It is also honoured in
  // IDLE and DROP so a branch resolving there is never lost.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_deliver     = 1'b0;
    w_capture     = 1'b0;
    w_deliver_dat = r_buf;

    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
        if (PCSrcE_i) begin
          w_pc_nxt = w_redirect_pc;
        end
      end

      S_REQ: begin
        if (PCSrcE_i) begin
          w_pc_nxt = w_redirect_pc;
          // If the old address was accepted, its response must be discarded.
          w_state_nxt = imem.imem_ready_i ? S_DROP : S_REQ;
        end else if (imem.imem_ready_i) begin
          w_state_nxt = S_WAIT;
        end
      end

      S_WAIT: begin
        if (PCSrcE_i) begin
          w_pc_nxt = w_redirect_pc;
          // A response arriving in the redirect cycle is the stale one; drop it here.
          w_state_nxt = w_rvalid ? S_REQ : S_DROP;
        end else if (w_rvalid) begin
          if (StallD_i) begin
            w_capture   = 1'b1;
            w_state_nxt = S_HOLD;
          end else begin
            w_deliver     = 1'b1;
            w_deliver_dat = imem.imem_rdata_i;
            w_pc_nxt      = w_pc_plus4;
            w_state_nxt   = S_REQ;
          end
        end
      end

      S_DROP: begin
        if (PCSrcE_i) begin
          w_pc_nxt = w_redirect_pc;
        end
        if (w_rvalid) begin
          w_state_nxt = S_REQ;
        end
      end

      S_HOLD: begin
        if (PCSrcE_i) begin
          w_pc_nxt    = w_redirect_pc;
          w_state_nxt = S_REQ;
        end else if (!StallD_i) begin
          w_deliver     = 1'b1;
          w_deliver_dat = r_buf;
          w_pc_nxt      = w_pc_plus4;
          w_state_nxt   = S_REQ;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // PC and holding buffer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc  <= RESET_PC;
      r_buf <= '0;
    end else begin
      r_pc <= w_pc_nxt;
      if (w_capture) begin
        r_buf <= imem.imem_rdata_i;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stale-response tracking across reset
  // While in reset, requests that were outstanding are added to the count and
  // any rvalid retires the oldest. Out of reset, rvalids retire the count first.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if (imem.imem_rvalid_i && (w_pending != 2'd0)) begin
        r_stale_cnt <= w_pending - 2'd1;
      end else begin
        r_stale_cnt <= w_pending;
      end
    end else if (imem.imem_rvalid_i && (r_stale_cnt != 2'd0)) begin
      r_stale_cnt <= r_stale_cnt - 2'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // IF/ID pipeline register
  // A flush or redirect bubbles the stage even when decode is stalled; bubbles
  // leave the PC fields untouched.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_instr      <= NOP_INSTR;
      r_pc_f       <= '0;
      r_pc_plus4_f <= '0;
      r_valid_d    <= 1'b0;
    end else if (FlushD_i || PCSrcE_i) begin
      r_instr   <= NOP_INSTR;
      r_valid_d <= 1'b0;
    end else if (StallD_i) begin
      r_instr      <= r_instr;
      r_pc_f       <= r_pc_f;
      r_pc_plus4_f <= r_pc_plus4_f;
      r_valid_d    <= r_valid_d;
    end else if (w_deliver) begin
      r_instr      <= w_deliver_dat;
      r_pc_f       <= r_pc;
      r_pc_plus4_f <= w_pc_plus4;
      r_valid_d    <= 1'b1;
    end else begin
      r_instr   <= NOP_INSTR;
      r_valid_d <= 1'b0;
    end
  end

  assign instr_o      = r_instr;
  assign PC_F_o       = r_pc_f;
  assign PC_Plus4_F_o = r_pc_plus4_f;
  assign validD_o     = r_valid_d;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the pipelined RV32I core. Owns the PC register and issues instruction-memory requests.
- Holds at most one request outstanding. Handles branch/jump redirects and stalls.
- Drives the IF/ID pipeline register that feeds decode's PC_F_i, PC_Plus4_F_i and instr_i inputs.

Parameters:
- DATA_WIDTH, 32, width of PC, addresses and instruction words.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0).

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- PCSrcE_i  input  1  redirect request from execute (taken branch/jump).
- PCTargetE_i  input  DATA_WIDTH  redirect target; bits [1:0] are ignored and forced to 0.
- StallD_i  input  1  hold the IF/ID register.
- FlushD_i  input  1  insert a bubble into the IF/ID register.
- imem_req_o  output  1  request valid.
- imem_addr_o  output  DATA_WIDTH  request word address.
- imem_ready_i  input  1  memory accepts the request this cycle.
- imem_rvalid_i  input  1  read data valid.
- imem_rdata_i  input  DATA_WIDTH  instruction word.
- instr_o  output  DATA_WIDTH  IF/ID instruction.
- PC_F_o  output  DATA_WIDTH  IF/ID PC of instr_o.
- PC_Plus4_F_o  output  DATA_WIDTH  IF/ID PC+4.
- validD_o  output  1  instr_o is a real instruction, not a bubble.

Behaviour:
- Reset: all state is updated on the clock edge when rst_n=0. Reset values:
  - pc_q=RESET_PC, state=IDLE.
  - imem_req_o=0, instr_o=NOP_INSTR, PC_F_o=0, PC_Plus4_F_o=0, validD_o=0, holding buffer empty.
- Reset asserted mid-transaction: an in-flight response is ignored. After rst_n rises, rvalid is only honoured for requests accepted after reset.
- Handshake rules:
  - A request is accepted on a cycle with imem_req_o=1 and imem_ready_i=1.
  - The response arrives one or more cycles later, in order, with exactly one rvalid per accepted request.
  - imem_addr_o=pc_q whenever imem_req_o=1.
  - While not accepted, the address may change only because of a redirect.
- FSM states and transitions:
  - IDLE: req=0. Next cycle goes to REQ.
  - REQ: req=1.
    - Redirect without ready: pc_q<=target, stay in REQ.
    - Redirect with ready: pc_q<=target, go to DROP (the old-address response must be discarded).
    - Ready without redirect: go to WAIT.
  - WAIT: req=0.
    - Redirect: pc_q<=target. Go to DROP, or directly to REQ if rvalid is high the same cycle (that data is discarded).
    - rvalid with StallD_i=0: deliver, pc_q<=pc_q+4, go to REQ.
    - rvalid with StallD_i=1: capture rdata in the holding buffer, pc stays, go to HOLD.
  - DROP: req=0. On rvalid, discard the data and go to REQ.
  - HOLD: req=0.
    - Redirect: empty the buffer, pc_q<=target, go to REQ.
    - StallD_i=0: deliver the buffer, pc_q<=pc_q+4, go to REQ.
- Deliver: in the same edge, instr_o<=data, PC_F_o<=pc_q, PC_Plus4_F_o<=pc_q+4, validD_o<=1.
- IF/ID update priority, evaluated each edge:
  1. Reset.
  2. FlushD_i or PCSrcE_i: bubble (instr_o=NOP_INSTR, validD_o=0, PCs hold their old values). This applies even if StallD_i=1.
  3. StallD_i: hold all IF/ID outputs.
  4. Deliver.
  5. Otherwise: bubble.
- Redirect and delivery in the same cycle: redirect wins. The fetched word is discarded and pc_q takes the target.
- Arithmetic: PC+4 is modulo 2^DATA_WIDTH, so 0xFFFF_FFFC+4 wraps to 0x0000_0000 with no flag.
- Zero-wait memory (ready=1 and rvalid in the cycle after acceptance) sustains one instruction every 2 cycles.
- Latency from acceptance to IF/ID valid is response latency + 1 edge.

Test Plan:
- Reset and first fetch: memory with ready=1 and rvalid 1 cycle after accept, rdata=0x00500093. Release rst_n. Required:
  - First req at addr 0x0.
  - validD_o=1, instr_o=0x00500093, PC_F_o=0, PC_Plus4_F_o=4.
  - Next req at addr 0x4.
- Back-pressure: imem_ready_i=0 for 5 cycles. Required:
  - req stays 1 and addr stays stable at 0x8.
  - validD_o=0 (bubbles) throughout.
  - Fetch completes once ready rises.
- Stall during response: StallD_i=1 when rvalid returns 0xDEADBEEF for PC 0xC, stall held 3 cycles. Required:
  - IF/ID holds its prior values during the stall.
  - After release, instr_o=0xDEADBEEF, PC_F_o=0xC.
  - No new request issued while in HOLD.
- Redirect in WAIT: PCSrcE_i=1 with PCTargetE_i=0x103 while waiting. Required:
  - Late response (rdata 0x11111111) never appears on instr_o.
  - Next req addr is 0x100.
  - validD_o=0 for that cycle.
- Flush vs stall: FlushD_i=1 and StallD_i=1 together. Required: instr_o=0x00000013, validD_o=0.
- Wrap: RESET_PC=0xFFFF_FFFC. Required: first delivery has PC_Plus4_F_o=0x0, and the next req addr is 0x0.
